// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module : alu_pkg
// Brief  : Opcodes, FSM state encoding and shared helpers for alu_multiciclo.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SLTU = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b0111;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b1001;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic es_desplazamiento(input logic [OP_W-1:0] op);
        return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_comb_n.sv
//------------------------------------------------------------------------------
// Module : alu_comb_n
// Brief  : Combinational WIDTH-bit logic/add/sub/compare datapath.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_comb_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = alu_pkg::OP_W
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] resultado_o,
    output logic             acarreo_o,
    output logic             desbordamiento_o,
    output logic             invalida_o
);

    logic             w_restar;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_suma;
    logic             w_carry;
    logic             w_ovf;

    // SLT/SLTU reuse the subtractor so compare and SUB share one adder.
    assign w_restar = (op_i == OP_SUB) || (op_i == OP_SLT) || (op_i == OP_SLTU);
    assign w_b_eff  = w_restar ? ~b_i : b_i;
    assign {w_carry, w_suma} = {1'b0, a_i} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_restar};
    assign w_ovf = (a_i[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_suma[WIDTH-1] != a_i[WIDTH-1]);

    always_comb begin
        resultado_o      = '0;
        acarreo_o        = 1'b0;
        desbordamiento_o = 1'b0;
        invalida_o       = 1'b0;
        case (op_i)
            OP_AND:  resultado_o = a_i & b_i;
            OP_OR:   resultado_o = a_i | b_i;
            OP_XOR:  resultado_o = a_i ^ b_i;
            OP_ADD, OP_SUB: begin
                resultado_o      = w_suma;
                acarreo_o        = w_carry;
                desbordamiento_o = w_ovf;
            end
            OP_SLT:  resultado_o = {{(WIDTH-1){1'b0}}, w_suma[WIDTH-1] ^ w_ovf};
            OP_SLTU: resultado_o = {{(WIDTH-1){1'b0}}, ~w_carry};
            // Shifts are sequenced by the top; not an invalid opcode here.
            OP_SRL, OP_SLL, OP_SRA: resultado_o = '0;
            default: invalida_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_multiciclo.sv
//------------------------------------------------------------------------------
// Module : alu_multiciclo
// Brief  : WIDTH-bit multi-cycle ALU, one-bit-per-cycle shifts, start/done.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OP_W    = alu_pkg::OP_W,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [OP_W-1:0]  operacion_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] resultado_o,
    output logic             cero_o,
    output logic             acarreo_o,
    output logic             desbordamiento_o,
    output logic             op_invalida_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t               estado_q;
    logic [WIDTH-1:0]     desp_q;
    logic [OP_W-1:0]      op_q;
    logic [SHAMT_W-1:0]   cuenta_q;
    logic [WIDTH-1:0]     resultado_q;
    logic                 cero_q;
    logic                 acarreo_q;
    logic                 ovf_q;
    logic                 invalida_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     desp_d;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]     w_res_comb;
    logic                 w_carry_comb;
    logic                 w_ovf_comb;
    logic                 w_inv_comb;

    assign w_shamt = b_i[SHAMT_W-1:0];

    alu_comb_n #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) u_comb (
        .a_i              (a_i),
        .b_i              (b_i),
        .op_i             (operacion_i),
        .resultado_o      (w_res_comb),
        .acarreo_o        (w_carry_comb),
        .desbordamiento_o (w_ovf_comb),
        .invalida_o       (w_inv_comb)
    );

    always_comb begin
        desp_d = desp_q;
        case (op_q)
            OP_SRL:  desp_d = {1'b0, desp_q[WIDTH-1:1]};
            OP_SLL:  desp_d = {desp_q[WIDTH-2:0], 1'b0};
            OP_SRA:  desp_d = {desp_q[WIDTH-1], desp_q[WIDTH-1:1]};
            default: desp_d = desp_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            estado_q    <= ST_IDLE;
            desp_q      <= '0;
            op_q        <= '0;
            cuenta_q    <= '0;
            resultado_q <= '0;
            cero_q      <= 1'b0;
            acarreo_q   <= 1'b0;
            ovf_q       <= 1'b0;
            invalida_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (estado_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (!es_desplazamiento(operacion_i)) begin
                            resultado_q <= w_res_comb;
                            cero_q      <= (w_res_comb == '0);
                            acarreo_q   <= w_carry_comb;
                            ovf_q       <= w_ovf_comb;
                            invalida_q  <= w_inv_comb;
                            done_q      <= 1'b1;
                        end else if (w_shamt == '0) begin
                            resultado_q <= a_i;
                            cero_q      <= (a_i == '0);
                            acarreo_q   <= 1'b0;
                            ovf_q       <= 1'b0;
                            invalida_q  <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            desp_q   <= a_i;
                            op_q     <= operacion_i;
                            cuenta_q <= w_shamt;
                            busy_q   <= 1'b1;
                            estado_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    desp_q   <= desp_d;
                    cuenta_q <= cuenta_q - 1'b1;
                    // Last step: the final shifted value goes straight to the output.
                    if (cuenta_q == SHAMT_W'(1)) begin
                        resultado_q <= desp_d;
                        cero_q      <= (desp_d == '0);
                        acarreo_q   <= 1'b0;
                        ovf_q       <= 1'b0;
                        invalida_q  <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        estado_q    <= ST_IDLE;
                    end
                end
                default: begin
                    estado_q <= ST_IDLE;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign resultado_o      = resultado_q;
    assign cero_o           = cero_q;
    assign acarreo_o        = acarreo_q;
    assign desbordamiento_o = ovf_q;
    assign op_invalida_o    = invalida_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule

`default_nettype wire
